conv_mac_array: RTL and testbench

CONV_MAC_ARRAY -- requirements
Module: conv_mac_array

---
 rtl/conv_mac_array.sv | 217 +++++++++++++++++++++
 tb/tb_conv_mac_array.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_array.sv
// conv_mac_array: LANES parallel signed multiply-accumulate lanes over a
// KERNEL_SIZE x KERNEL_SIZE kernel, fed and drained by AXI-Stream style
// handshakes. Pipeline: product register -> accumulator -> output register.
// The final tap reaches the output register two edges after it is accepted.
// One global stall freezes every stage whenever the output is held.
`timescale 1ns/1ps

module conv_mac_array #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned LANES       = 4,
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned SHIFT       = 8
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic                       slv_valid,
    output logic                       slv_ready,
    input  logic [LANES*2*WIDTH-1:0]   slv_data,
    input  logic                       slv_last,
    output logic                       mst_valid,
    input  logic                       mst_ready,
    output logic [LANES*WIDTH-1:0]     mst_data,
    output logic                       mst_last,
    input  logic                       relu_en,
    output logic                       sat_flag,
    output logic                       err_short
);

    localparam int unsigned TAPS   = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int unsigned PROD_W = 2 * WIDTH;
    // Worst case sum of TAPS full-precision products fits without overflow.
    localparam int unsigned ACC_W  = PROD_W + $clog2(TAPS);

    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

    // Clip bounds sign-extended to accumulator width.
    localparam logic signed [ACC_W-1:0] MAX_V =
        $signed({{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] MIN_V =
        $signed({{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}});

    logic                      ready_en_q;
    logic                      stall;
    logic                      accept;
    logic                      final_tap;

    logic [TAP_W-1:0]          tap_q;

    logic signed [PROD_W-1:0]  prod_d     [LANES];
    logic signed [PROD_W-1:0]  s1_prod_q  [LANES];
    logic [TAP_W-1:0]          s1_tap_q;
    logic                      s1_valid_q;
    logic                      s1_final_q;
    logic                      s1_last_q;

    logic signed [ACC_W-1:0]   acc_d      [LANES];
    logic signed [ACC_W-1:0]   acc_q      [LANES];
    logic                      s2_done_q;
    logic                      s2_last_q;

    logic [LANES*WIDTH-1:0]    out_d;
    logic                      clip_any;

    logic                      mst_valid_q;
    logic [LANES*WIDTH-1:0]    mst_data_q;
    logic                      mst_last_q;
    logic                      sat_q;
    logic                      err_q;

    // Handshake glue: ready is held low through reset and the first edge after it.
    always_comb begin
        stall     = mst_valid_q && !mst_ready;
        slv_ready = ready_en_q && !stall;
        accept    = slv_valid && slv_ready;
        final_tap = slv_last || (tap_q == LAST_TAP);
        mst_valid = mst_valid_q;
        mst_data  = mst_data_q;
        mst_last  = mst_last_q;
        sat_flag  = sat_q;
        err_short = err_q;
    end

    // Per-lane full-precision signed products of the incoming beat.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_d[i] = PROD_W'($signed(slv_data[PROD_W*i+WIDTH +: WIDTH]))
                      * PROD_W'($signed(slv_data[PROD_W*i +: WIDTH]));
        end
    end

    // Accumulator next value: tap 0 restarts the sum.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            if (s1_tap_q == '0) begin
                acc_d[i] = ACC_W'(s1_prod_q[i]);
            end else begin
                acc_d[i] = acc_q[i] + ACC_W'(s1_prod_q[i]);
            end
        end
    end

    // Shift, clip and optional ReLU of the completed sums.
    always_comb begin
        logic signed [ACC_W-1:0] sh;
        logic [WIDTH-1:0]        r;
        out_d    = '0;
        clip_any = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            sh = acc_q[i] >>> SHIFT;
            if (sh > MAX_V) begin
                r        = MAX_V[WIDTH-1:0];
                clip_any = 1'b1;
            end else if (sh < MIN_V) begin
                r        = MIN_V[WIDTH-1:0];
                clip_any = 1'b1;
            end else begin
                r = sh[WIDTH-1:0];
            end
            if (relu_en && r[WIDTH-1]) begin
                r = '0;
            end
            out_d[WIDTH*i +: WIDTH] = r;
        end
    end

    // Input ready enable rises on the first edge out of reset.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    // Tap counter: wraps after the final tap or any frame-last beat.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            tap_q <= '0;
        end else if (accept) begin
            tap_q <= final_tap ? '0 : tap_q + TAP_W'(1);
        end
    end

    // Stage 1: register products with tap index and end-of-kernel tags.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid_q <= 1'b0;
            s1_tap_q   <= '0;
            s1_final_q <= 1'b0;
            s1_last_q  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1_prod_q[i] <= '0;
            end
        end else if (!stall) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_tap_q   <= tap_q;
                s1_final_q <= final_tap;
                s1_last_q  <= slv_last;
                for (int i = 0; i < LANES; i++) begin
                    s1_prod_q[i] <= prod_d[i];
                end
            end
        end
    end

    // Stage 2: accumulate; flag a completed sum on the final or frame-last tap.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            s2_done_q <= 1'b0;
            s2_last_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= '0;
            end
        end else if (!stall) begin
            s2_done_q <= s1_valid_q && s1_final_q;
            if (s1_valid_q) begin
                s2_last_q <= s1_last_q;
                for (int i = 0; i < LANES; i++) begin
                    acc_q[i] <= acc_d[i];
                end
            end
        end
    end

    // Output register: load a finished result, else drop valid after handshake.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            mst_valid_q <= 1'b0;
            mst_data_q  <= '0;
            mst_last_q  <= 1'b0;
        end else if (!stall) begin
            mst_valid_q <= s2_done_q;
            if (s2_done_q) begin
                mst_data_q <= out_d;
                mst_last_q <= s2_last_q;
            end
        end
    end

    // Sticky status: saturation on load, short frame on acceptance.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sat_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (!stall && s2_done_q && clip_any) begin
                sat_q <= 1'b1;
            end
            if (accept && slv_last && (tap_q != LAST_TAP)) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_array.sv
// Directed bench for conv_mac_array: default 4-lane 3x3 instance plus a
// 1-lane 1x1 instance with SHIFT=2, hand-computed expected results.
`timescale 1ns/1ps

module tb_conv_mac_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic aresetn;

    logic         a_slv_valid, a_slv_ready, a_slv_last;
    logic [127:0] a_slv_data;
    logic         a_mst_valid, a_mst_ready, a_mst_last;
    logic [63:0]  a_mst_data;
    logic         a_relu, a_sat, a_err;

    logic         b_slv_valid, b_slv_ready, b_slv_last;
    logic [31:0]  b_slv_data;
    logic         b_mst_valid, b_mst_ready, b_mst_last;
    logic [15:0]  b_mst_data;
    logic         b_sat, b_err;

    conv_mac_array #(
        .WIDTH(16), .LANES(4), .KERNEL_SIZE(3), .SHIFT(0)
    ) u_dut_a (
        .clk(clk), .aresetn(aresetn),
        .slv_valid(a_slv_valid), .slv_ready(a_slv_ready),
        .slv_data(a_slv_data), .slv_last(a_slv_last),
        .mst_valid(a_mst_valid), .mst_ready(a_mst_ready),
        .mst_data(a_mst_data), .mst_last(a_mst_last),
        .relu_en(a_relu), .sat_flag(a_sat), .err_short(a_err)
    );

    conv_mac_array #(
        .WIDTH(16), .LANES(1), .KERNEL_SIZE(1), .SHIFT(2)
    ) u_dut_b (
        .clk(clk), .aresetn(aresetn),
        .slv_valid(b_slv_valid), .slv_ready(b_slv_ready),
        .slv_data(b_slv_data), .slv_last(b_slv_last),
        .mst_valid(b_mst_valid), .mst_ready(b_mst_ready),
        .mst_data(b_mst_data), .mst_last(b_mst_last),
        .relu_en(1'b0), .sat_flag(b_sat), .err_short(b_err)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int a_last_acc  = 0;
    int b_first     = 0;

    logic [63:0] qa_data[$];
    logic        qa_last[$];
    int          qa_cyc[$];
    logic [15:0] qb_data[$];
    logic        qb_last[$];
    int          qb_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output handshake that the coming rising edge will complete.
    always @(negedge clk) begin
        if (a_mst_valid && a_mst_ready) begin
            qa_data.push_back(a_mst_data);
            qa_last.push_back(a_mst_last);
            qa_cyc.push_back(cyc);
        end
        if (b_mst_valid && b_mst_ready) begin
            qb_data.push_back(b_mst_data);
            qb_last.push_back(b_mst_last);
            qb_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        qa_data.delete(); qa_last.delete(); qa_cyc.delete();
        qb_data.delete(); qb_last.delete(); qb_cyc.delete();
    endtask

    // Present one beat on all lanes and hold it until accepted.
    task automatic send_a(input logic [15:0] pix, input logic [15:0] wt, input logic last);
        int   n;
        logic ok;
        a_slv_data  = {4{pix, wt}};
        a_slv_last  = last;
        a_slv_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            ok = a_slv_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
        a_last_acc  = cyc;
        a_slv_valid = 1'b0;
        a_slv_last  = 1'b0;
    endtask

    task automatic send_kernel(input logic [15:0] pix, input logic [15:0] wt,
                               input int n, input logic last);
        for (int i = 0; i < n; i++) begin
            send_a(pix, wt, last && (i == n - 1));
        end
    endtask

    // Wait (bounded) for n outputs, then a few idle cycles to expose extras.
    task automatic wait_a(input int n);
        int k = 0;
        while (qa_data.size() < n && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("out_count", 64'(qa_data.size()), 64'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        aresetn     = 1'b0;
        a_slv_valid = 1'b0; a_slv_last = 1'b0; a_slv_data = '0;
        a_mst_ready = 1'b1; a_relu = 1'b0;
        b_slv_valid = 1'b0; b_slv_last = 1'b0; b_slv_data = '0;
        b_mst_ready = 1'b1;

        // Reset state and ready release timing.
        @(posedge clk); #1;
        check("rst_valid", 64'(a_mst_valid), 64'd0);
        check("rst_data", a_mst_data, 64'd0);
        check("rst_last", 64'(a_mst_last), 64'd0);
        check("rst_ready", 64'(a_slv_ready), 64'd0);
        check("rst_flags", {62'd0, a_sat, a_err}, 64'd0);
        @(posedge clk); #1;
        aresetn = 1'b1;
        @(negedge clk);
        check("ready_pre_edge", 64'(a_slv_ready), 64'd0);
        @(posedge clk); #1;
        check("ready_post_edge", 64'(a_slv_ready), 64'd1);

        // 9 taps of 2*1 -> 18 per lane, frame last, two-edge latency.
        clear_q();
        send_kernel(16'd2, 16'd1, 9, 1'b1);
        wait_a(1);
        check("k9_data", qa_data[0], {4{16'd18}});
        check("k9_last", 64'(qa_last[0]), 64'd1);
        check("k9_latency", 64'(qa_cyc[0] - a_last_acc), 64'd2);
        check("k9_flags", {62'd0, a_sat, a_err}, 64'd0);

        // Positive overflow clips to max and sets sat_flag.
        clear_q();
        send_kernel(16'h7fff, 16'h7fff, 9, 1'b1);
        wait_a(1);
        check("sat_pos_data", qa_data[0], {4{16'h7fff}});
        check("sat_pos_flag", 64'(a_sat), 64'd1);

        // Negative overflow with ReLU -> 0, sat_flag stays set.
        clear_q();
        a_relu = 1'b1;
        send_kernel(16'h8000, 16'h7fff, 9, 1'b1);
        wait_a(1);
        a_relu = 1'b0;
        check("relu_data", qa_data[0], 64'd0);
        check("relu_sat_sticky", 64'(a_sat), 64'd1);

        // Frame ends on tap 3: flush 4, err_short, next beat restarts at tap 0.
        clear_q();
        send_kernel(16'd1, 16'd1, 4, 1'b1);
        wait_a(1);
        check("short_data", qa_data[0], {4{16'd4}});
        check("short_last", 64'(qa_last[0]), 64'd1);
        check("short_err", 64'(a_err), 64'd1);
        clear_q();
        send_kernel(16'd2, 16'd1, 9, 1'b1);
        wait_a(1);
        check("after_short_data", qa_data[0], {4{16'd18}});

        // 18-beat stream with output held for 5 cycles at the first result.
        clear_q();
        a_mst_ready = 1'b0;
        fork
            begin
                send_kernel(16'd2, 16'd1, 9, 1'b0);
                send_kernel(16'd2, 16'd1, 9, 1'b1);
            end
            begin
                int k = 0;
                while (!a_mst_valid && k < 100) begin
                    @(posedge clk); #1;
                    k++;
                end
                for (int i = 0; i < 5; i++) begin
                    check("stall_ready", 64'(a_slv_ready), 64'd0);
                    check("stall_data", a_mst_data, {4{16'd18}});
                    check("stall_valid", 64'(a_mst_valid), 64'd1);
                    @(posedge clk); #1;
                end
                a_mst_ready = 1'b1;
            end
        join
        wait_a(2);
        check("stream0_data", qa_data[0], {4{16'd18}});
        check("stream0_last", 64'(qa_last[0]), 64'd0);
        check("stream1_data", qa_data[1], {4{16'd18}});
        check("stream1_last", 64'(qa_last[1]), 64'd1);

        // Reset after 5 taps discards the partial sum and the flags.
        clear_q();
        send_kernel(16'd2, 16'd1, 5, 1'b0);
        aresetn = 1'b0;
        #1;
        check("mid_rst_valid", 64'(a_mst_valid), 64'd0);
        check("mid_rst_data", a_mst_data, 64'd0);
        check("mid_rst_flags", {61'd0, a_sat, a_err, a_slv_ready}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(posedge clk); #1;
        clear_q();
        send_kernel(16'd2, 16'd1, 9, 1'b1);
        wait_a(1);
        check("post_rst_data", qa_data[0], {4{16'd18}});
        check("post_rst_last", 64'(qa_last[0]), 64'd1);

        // 1x1 kernel, SHIFT=2: -7*3 = -21 >>> 2 = -6 on every beat.
        clear_q();
        b_slv_valid = 1'b1;
        b_slv_data  = {16'hfff9, 16'h0003};
        for (int i = 0; i < 4; i++) begin
            b_slv_last = (i == 3);
            @(negedge clk);
            check("b_ready", 64'(b_slv_ready), 64'd1);
            @(posedge clk); #1;
            if (i == 0) b_first = cyc;
        end
        b_slv_valid = 1'b0;
        b_slv_last  = 1'b0;
        begin
            int k = 0;
            while (qb_data.size() < 4 && k < 40) begin
                @(posedge clk); #1;
                k++;
            end
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("b_count", 64'(qb_data.size()), 64'd4);
        if (qb_data.size() == 4) begin
            check("b_latency", 64'(qb_cyc[0] - b_first), 64'd2);
            for (int i = 0; i < 4; i++) begin
                check("b_data", 64'(qb_data[i]), 64'(16'hfffa));
                check("b_rate", 64'(qb_cyc[i] - qb_cyc[0]), 64'(i));
                check("b_last", 64'(qb_last[i]), (i == 3) ? 64'd1 : 64'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
